// File: rtl/isa_cycle_initiator_pkg.sv
// Shared definitions for the ISA cycle initiator: command encodings,
// FSM state codes, default bus timings and small decode helpers.
package isa_cycle_initiator_pkg;

    // Command type encodings as seen on cmd_type
    localparam logic [1:0] ISA_MEMR = 2'b00;
    localparam logic [1:0] ISA_MEMW = 2'b01;
    localparam logic [1:0] ISA_IOR  = 2'b10;
    localparam logic [1:0] ISA_IOW  = 2'b11;

    // FSM state codes
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_STROBE  = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_HOLD    = 3'd4;
    localparam logic [2:0] ST_RECOVER = 3'd5;

    // Default bus timings in clk cycles
    localparam int DEF_ADDR_SETUP  = 2;
    localparam int DEF_STROBE_MIN  = 6;
    localparam int DEF_HOLD        = 2;
    localparam int DEF_RECOVERY    = 2;
    localparam int DEF_RDY_TIMEOUT = 255;

    // One latched command
    typedef struct packed {
        logic [1:0]  cmd_type;
        logic [19:0] addr;
        logic [7:0]  wdata;
    } isa_cmd_t;

    // True for the two command types that drive data onto the bus
    function automatic logic is_write(input logic [1:0] t);
        return (t == ISA_MEMW) || (t == ISA_IOW);
    endfunction

    // Active-low strobe vector {iow, ior, memw, memr} with only the selected strobe low
    function automatic logic [3:0] strobe_sel_l(input logic [1:0] t);
        logic [3:0] s;
        s = 4'b1111;
        case (t)
            ISA_MEMR: s = 4'b1110;
            ISA_MEMW: s = 4'b1101;
            ISA_IOR:  s = 4'b1011;
            ISA_IOW:  s = 4'b0111;
            default:  s = 4'b1111;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/isa_sync2.sv
// Generic two-flop synchronizer for a single asynchronous level.
// The reset value is a parameter so the consumer sees a benign level during reset.
module isa_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_l,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next-state: shift the async level through two stages
    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    // Synchronizer flops, forced to the benign level in reset
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/isa_cycle_initiator.sv
// ISA bus initiator: turns single command requests into timed MEMR/MEMW/IOR/IOW
// cycles with bus_rdy wait-state handling and a wait timeout. All outputs registered.
module isa_cycle_initiator
    import isa_cycle_initiator_pkg::*;
#(
    parameter int ADDR_SETUP  = DEF_ADDR_SETUP,
    parameter int STROBE_MIN  = DEF_STROBE_MIN,
    parameter int HOLD        = DEF_HOLD,
    parameter int RECOVERY    = DEF_RECOVERY,
    parameter int RDY_TIMEOUT = DEF_RDY_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_type,
    input  logic [19:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_timeout,
    output logic [19:0] bus_a,
    output logic        bus_memr_l,
    output logic        bus_memw_l,
    output logic        bus_ior_l,
    output logic        bus_iow_l,
    output logic        bus_aen,
    output logic [7:0]  bus_d_out,
    output logic        bus_d_oe,
    input  logic [7:0]  bus_d_in,
    input  logic        bus_rdy
);

    // SETUP counts one extra cycle because the address is driven on the edge after accept
    localparam logic [7:0] SETUP_LD   = 8'(ADDR_SETUP);
    localparam logic [7:0] STROBE_LD  = 8'(STROBE_MIN - 1);
    localparam logic [7:0] HOLD_LD    = 8'(HOLD - 1);
    localparam logic [7:0] RECOVER_LD = 8'(RECOVERY - 1);
    localparam logic [7:0] TIMEOUT_CT = 8'(RDY_TIMEOUT);

    logic        rdy_s;

    logic [2:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    isa_cmd_t    cmd_q, cmd_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        tmo_q, tmo_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        rsp_timeout_q, rsp_timeout_d;
    logic [19:0] bus_a_q, bus_a_d;
    logic [3:0]  strobe_l_q, strobe_l_d;
    logic        aen_q, aen_d;
    logic [7:0]  d_out_q, d_out_d;
    logic        d_oe_q, d_oe_d;

    isa_sync2 #(.RESET_VAL(1'b1)) u_rdy_sync (
        .clk      (clk),
        .reset_l  (reset_l),
        .async_in (bus_rdy),
        .sync_out (rdy_s)
    );

    // Cycle sequencer: one shared counter, down-counting in timed phases and up-counting in WAIT
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cmd_d         = cmd_q;
        rdata_d       = rdata_q;
        tmo_d         = tmo_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = rsp_timeout_q;
        bus_a_d       = bus_a_q;
        strobe_l_d    = strobe_l_q;
        aen_d         = aen_q;
        d_out_d       = d_out_q;
        d_oe_d        = d_oe_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_d.cmd_type = cmd_type;
                    cmd_d.addr     = cmd_addr;
                    cmd_d.wdata    = cmd_wdata;
                    rdata_d        = 8'h00;
                    tmo_d          = 1'b0;
                    cnt_d          = SETUP_LD;
                    state_d        = ST_SETUP;
                end
            end
            ST_SETUP: begin
                bus_a_d = cmd_q.addr;
                aen_d   = 1'b0;
                if (is_write(cmd_q.cmd_type)) begin
                    d_oe_d  = 1'b1;
                    d_out_d = cmd_q.wdata;
                end
                if (cnt_q == 8'd0) begin
                    strobe_l_d = strobe_sel_l(cmd_q.cmd_type);
                    cnt_d      = STROBE_LD;
                    state_d    = ST_STROBE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_STROBE: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (rdy_s) begin
                    if (!is_write(cmd_q.cmd_type)) begin
                        rdata_d = bus_d_in;
                    end
                    strobe_l_d = 4'b1111;
                    cnt_d      = HOLD_LD;
                    state_d    = ST_HOLD;
                end else begin
                    cnt_d   = 8'd1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (rdy_s) begin
                    if (!is_write(cmd_q.cmd_type)) begin
                        rdata_d = bus_d_in;
                    end
                    strobe_l_d = 4'b1111;
                    cnt_d      = HOLD_LD;
                    state_d    = ST_HOLD;
                end else if (cnt_q == TIMEOUT_CT) begin
                    rdata_d    = 8'hFF;
                    tmo_d      = 1'b1;
                    strobe_l_d = 4'b1111;
                    cnt_d      = HOLD_LD;
                    state_d    = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 8'd0) begin
                    aen_d         = 1'b1;
                    d_oe_d        = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = rdata_q;
                    rsp_timeout_d = tmo_q;
                    cnt_d         = RECOVER_LD;
                    state_d       = ST_RECOVER;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_RECOVER: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                strobe_l_d = 4'b1111;
                aen_d      = 1'b1;
                d_oe_d     = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset releases the bus immediately, even mid-cycle
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 8'd0;
            cmd_q         <= '0;
            rdata_q       <= 8'h00;
            tmo_q         <= 1'b0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 8'h00;
            rsp_timeout_q <= 1'b0;
            bus_a_q       <= 20'h00000;
            strobe_l_q    <= 4'b1111;
            aen_q         <= 1'b1;
            d_out_q       <= 8'h00;
            d_oe_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_q         <= cmd_d;
            rdata_q       <= rdata_d;
            tmo_q         <= tmo_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
            bus_a_q       <= bus_a_d;
            strobe_l_q    <= strobe_l_d;
            aen_q         <= aen_d;
            d_out_q       <= d_out_d;
            d_oe_q        <= d_oe_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_timeout = rsp_timeout_q;
    assign bus_a       = bus_a_q;
    assign bus_memr_l  = strobe_l_q[0];
    assign bus_memw_l  = strobe_l_q[1];
    assign bus_ior_l   = strobe_l_q[2];
    assign bus_iow_l   = strobe_l_q[3];
    assign bus_aen     = aen_q;
    assign bus_d_out   = d_out_q;
    assign bus_d_oe    = d_oe_q;

endmodule
